control_word_decoder: RTL and testbench

Consumer end of the 38-bit microcode control word produced by the control store sequencer. It registers each control word and decodes it into one-hot bus-source enables, register write strobes, an ALU opcode and a PC-increment strobe. It runs the memory request/acknowledge handshake for the 3-bit memory field, and drives `stall` back to the sequencer so the sequencer holds the current word until the access completes. It sits between the control store and the datapath/memory.

---
 rtl/control_word_decoder_if.sv | 33 +++
 rtl/control_word_decoder.sv | 184 ++++++++++++++++++
 tb/tb_control_word_decoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_word_decoder_if.sv
// Sequencer/memory-facing bundle of the control word decoder: control word in, decoded strobes,
// memory handshake and status out. Master = sequencer/memory side, slave = decoder.
interface control_word_decoder_if #(
    parameter int NSRC = 18
);
    logic [37:0]     cw;
    logic            mem_ack;
    logic [7:0]      mem_rdata;
    logic [3:0]      alu_op;
    logic [18:0]     reg_we;
    logic [NSRC-1:0] bus_oe;
    logic            pc_inc;
    logic            mem_req;
    logic            mem_we;
    logic            mem_isel;
    logic [7:0]      rdata;
    logic            rdata_valid;
    logic            stall;
    logic            err_illegal;
    logic            err_timeout;

    modport master (
        output cw, mem_ack, mem_rdata,
        input  alu_op, reg_we, bus_oe, pc_inc, mem_req, mem_we, mem_isel,
               rdata, rdata_valid, stall, err_illegal, err_timeout
    );

    modport slave (
        input  cw, mem_ack, mem_rdata,
        output alu_op, reg_we, bus_oe, pc_inc, mem_req, mem_we, mem_isel,
               rdata, rdata_valid, stall, err_illegal, err_timeout
    );
endinterface

// File: rtl/control_word_decoder.sv
// Registers and decodes the 38-bit microcode word (1-cycle latency) and runs the mem req/ack access.
// Backpressure: stall holds the sequencer from sampling a memory word until the DONE cycle.
module control_word_decoder #(
    parameter int TIMEOUT = 16,
    parameter int NSRC    = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    control_word_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_cnt;
    logic [15:0]     w_cnt_nxt;
    logic            w_ack_hit;
    logic            w_timeout_hit;
    logic            w_idle;

    logic [3:0]      w_alu;
    logic [18:0]     w_we;
    logic [2:0]      w_mem_fld;
    logic            w_pc;
    logic [4:0]      w_src;
    logic            w_src_ok;
    logic [NSRC-1:0] w_onehot;
    logic            w_mem_go;
    logic            w_mem_bad;
    logic            w_mem_we;
    logic            w_mem_isel;
    logic            w_unused;

    logic [3:0]      r_alu_op;
    logic [18:0]     r_reg_we;
    logic [NSRC-1:0] r_bus_oe;
    logic            r_pc_inc;
    logic            r_mem_we;
    logic            r_mem_isel;
    logic [7:0]      r_rdata;
    logic            r_rdata_valid;
    logic            r_err_illegal;
    logic            r_err_timeout;

    assign w_alu     = bus.cw[31:28];
    assign w_we      = bus.cw[27:9];
    assign w_mem_fld = bus.cw[8:6];
    assign w_pc      = bus.cw[5];
    assign w_src     = bus.cw[4:0];
    // Next-address bits belong to the sequencer and are not used here.
    assign w_unused  = ^bus.cw[37:32];

    assign w_idle    = (r_state == IDLE);

    always_comb begin
        w_mem_go   = 1'b0;
        w_mem_bad  = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_isel = 1'b0;
        case (w_mem_fld)
            3'b000: w_mem_go = 1'b0;
            3'b100: begin
                w_mem_go   = 1'b1;
                w_mem_isel = 1'b1;
            end
            3'b010: w_mem_go = 1'b1;
            3'b001: begin
                w_mem_go = 1'b1;
                w_mem_we = 1'b1;
            end
            default: w_mem_bad = 1'b1;
        endcase
    end

    // Out-of-range codes match no bit, so bus_oe is all-zero for them.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_onehot[i] = (32'(w_src) == i);
        end
    end

    assign w_src_ok = (32'(w_src) < NSRC);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ack_hit     = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_go) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                // Ack is tested first so an ack coinciding with the last count wins.
                if (bus.mem_ack) begin
                    w_state_nxt = DONE;
                    w_ack_hit   = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = DONE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op      <= '0;
            r_reg_we      <= '0;
            r_bus_oe      <= '0;
            r_pc_inc      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_isel    <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            if (w_idle) begin
                r_alu_op   <= w_alu;
                r_reg_we   <= w_we;
                r_pc_inc   <= w_pc;
                r_bus_oe   <= w_onehot;
                r_mem_we   <= w_mem_we;
                r_mem_isel <= w_mem_isel;
                if (!w_src_ok || w_mem_bad) begin
                    r_err_illegal <= 1'b1;
                end
            end else begin
                // Strobes fire once per word: cleared while the access is in flight.
                r_reg_we <= '0;
                r_pc_inc <= 1'b0;
            end
            if (w_ack_hit && !r_mem_we) begin
                r_rdata       <= bus.mem_rdata;
                r_rdata_valid <= 1'b1;
            end
            if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign bus.alu_op      = r_alu_op;
    assign bus.reg_we      = r_reg_we;
    assign bus.bus_oe      = r_bus_oe;
    assign bus.pc_inc      = r_pc_inc;
    assign bus.mem_req     = (r_state == ACCESS);
    assign bus.mem_we      = (r_state == ACCESS) & r_mem_we;
    assign bus.mem_isel    = (r_state == ACCESS) & r_mem_isel;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_timeout = r_err_timeout;
    // rst_n gating keeps stall low during reset even if cw carries a memory word.
    assign bus.stall       = rst_n & ((r_state == ACCESS) | (w_idle & w_mem_go));

endmodule

// File: tb/tb_control_word_decoder.sv
// Directed bench for control_word_decoder: expected values are queued when a step is driven
// and popped against the DUT outputs once that step has taken effect.
module tb_control_word_decoder;
    localparam int NSRC    = 18;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n;

    control_word_decoder_if #(.NSRC(NSRC)) ifc ();

    control_word_decoder #(.TIMEOUT(TIMEOUT), .NSRC(NSRC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_req   = 0;
    int   n_rv    = 0;
    int   n_we    = 0;

    function automatic logic [37:0] mk_cw(logic [3:0] alu, logic [18:0] we, logic [2:0] mem,
                                          logic pc, logic [4:0] src);
        return {6'd0, alu, we, mem, pc, src};
    endfunction

    task automatic push_exp(string tag, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check(logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty observed=%0h expected=queued_entry", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    // One clock, sampled 1 time unit after the rising edge; activity counters accumulate here.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ifc.mem_req)       n_req++;
        if (ifc.rdata_valid)   n_rv++;
        if (ifc.reg_we != '0)  n_we++;
    endtask

    task automatic check_all_zero(string tag);
        push_exp({tag, "_alu"}, 32'd0);   check(32'(ifc.alu_op));
        push_exp({tag, "_we"}, 32'd0);    check(32'(ifc.reg_we));
        push_exp({tag, "_oe"}, 32'd0);    check(32'(ifc.bus_oe));
        push_exp({tag, "_pc"}, 32'd0);    check(32'(ifc.pc_inc));
        push_exp({tag, "_req"}, 32'd0);   check(32'(ifc.mem_req));
        push_exp({tag, "_mwe"}, 32'd0);   check(32'(ifc.mem_we));
        push_exp({tag, "_isel"}, 32'd0);  check(32'(ifc.mem_isel));
        push_exp({tag, "_rdata"}, 32'd0); check(32'(ifc.rdata));
        push_exp({tag, "_rv"}, 32'd0);    check(32'(ifc.rdata_valid));
        push_exp({tag, "_stall"}, 32'd0); check(32'(ifc.stall));
        push_exp({tag, "_eill"}, 32'd0);  check(32'(ifc.err_illegal));
        push_exp({tag, "_eto"}, 32'd0);   check(32'(ifc.err_timeout));
    endtask

    task automatic check_decode(string tag, logic [3:0] alu, logic [18:0] we,
                                logic [NSRC-1:0] oe, logic pc);
        push_exp({tag, "_alu"}, 32'(alu)); check(32'(ifc.alu_op));
        push_exp({tag, "_we"}, 32'(we));   check(32'(ifc.reg_we));
        push_exp({tag, "_oe"}, 32'(oe));   check(32'(ifc.bus_oe));
        push_exp({tag, "_pc"}, 32'(pc));   check(32'(ifc.pc_inc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with an all-ones word on the bus.
        rst_n         = 1'b0;
        ifc.cw        = 38'h3F_FFFF_FFFF;
        ifc.mem_ack   = 1'b0;
        ifc.mem_rdata = 8'h00;
        #1;
        check_all_zero("rst");
        tick();
        tick();
        check_all_zero("rst_held");

        // Release with a MULK-style word; it is sampled at the next edge.
        rst_n  = 1'b1;
        ifc.cw = mk_cw(4'b0011, 19'd1, 3'b000, 1'b0, 5'd2);
        push_exp("mulk_stall_pre", 32'd0); check(32'(ifc.stall));
        tick();
        check_decode("mulk", 4'd3, 19'd1, 18'h00004, 1'b0);
        push_exp("mulk_stall", 32'd0);  check(32'(ifc.stall));
        push_exp("mulk_req", 32'd0);    check(32'(ifc.mem_req));
        push_exp("mulk_eill", 32'd0);   check(32'(ifc.err_illegal));

        // Back-to-back non-memory words, one per cycle.
        ifc.cw = mk_cw(4'hA, 19'h40000, 3'b000, 1'b1, 5'd17);
        tick();
        check_decode("b2b1", 4'hA, 19'h40000, 18'h20000, 1'b1);
        ifc.cw = mk_cw(4'h5, 19'd0, 3'b000, 1'b0, 5'd0);
        tick();
        check_decode("b2b2", 4'h5, 19'd0, 18'h00001, 1'b0);

        // Data read acked in the third ACCESS cycle.
        ifc.cw = mk_cw(4'h7, 19'h00100, 3'b010, 1'b1, 5'd3);
        #1;
        push_exp("rd_stall_pre", 32'd1); check(32'(ifc.stall));
        n_req = 0; n_rv = 0; n_we = 0;
        tick();
        check_decode("rd_a1", 4'h7, 19'h00100, 18'h00008, 1'b1);
        push_exp("rd_req", 32'd1);   check(32'(ifc.mem_req));
        push_exp("rd_mwe", 32'd0);   check(32'(ifc.mem_we));
        push_exp("rd_isel", 32'd0);  check(32'(ifc.mem_isel));
        push_exp("rd_stall", 32'd1); check(32'(ifc.stall));
        tick();
        push_exp("rd_a2_we", 32'd0); check(32'(ifc.reg_we));
        tick();
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = 8'hA5;
        tick();
        ifc.mem_ack   = 1'b0;
        ifc.mem_rdata = 8'h00;
        push_exp("rd_done_req", 32'd0);   check(32'(ifc.mem_req));
        push_exp("rd_done_stall", 32'd0); check(32'(ifc.stall));
        push_exp("rd_rdata", 32'hA5);     check(32'(ifc.rdata));
        push_exp("rd_rv", 32'd1);         check(32'(ifc.rdata_valid));
        push_exp("rd_alu_hold", 32'h7);   check(32'(ifc.alu_op));
        push_exp("rd_oe_hold", 32'h8);    check(32'(ifc.bus_oe));
        ifc.cw = mk_cw(4'h2, 19'd0, 3'b000, 1'b0, 5'd1);
        tick();
        push_exp("rd_rv_end", 32'd0); check(32'(ifc.rdata_valid));
        tick();
        check_decode("rd_next", 4'h2, 19'd0, 18'h00002, 1'b0);
        push_exp("rd_req_cycles", 32'd3); check(32'(n_req));
        push_exp("rd_rv_pulses", 32'd1);  check(32'(n_rv));
        push_exp("rd_we_pulses", 32'd1);  check(32'(n_we));

        // Instruction read acked on the same edge the counter expires: ack wins.
        ifc.cw = mk_cw(4'h4, 19'd0, 3'b100, 1'b0, 5'd6);
        n_req = 0; n_rv = 0;
        tick();
        push_exp("ir_isel", 32'd1); check(32'(ifc.mem_isel));
        push_exp("ir_mwe", 32'd0);  check(32'(ifc.mem_we));
        tick();
        tick();
        tick();
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = 8'h5A;
        tick();
        ifc.mem_ack   = 1'b0;
        ifc.cw        = mk_cw(4'h1, 19'd0, 3'b000, 1'b0, 5'd0);
        push_exp("ir_eto", 32'd0);        check(32'(ifc.err_timeout));
        push_exp("ir_rdata", 32'h5A);     check(32'(ifc.rdata));
        push_exp("ir_rv", 32'd1);         check(32'(ifc.rdata_valid));
        push_exp("ir_req_cycles", 32'd4); check(32'(n_req));
        tick();
        tick();

        // Data write with no ack: aborts after TIMEOUT cycles, a late ack is ignored.
        ifc.cw = mk_cw(4'h1, 19'd0, 3'b001, 1'b0, 5'd0);
        n_req = 0; n_rv = 0;
        tick();
        push_exp("wr_mwe", 32'd1);  check(32'(ifc.mem_we));
        push_exp("wr_isel", 32'd0); check(32'(ifc.mem_isel));
        tick();
        tick();
        tick();
        push_exp("wr_eto_pre", 32'd0); check(32'(ifc.err_timeout));
        tick();
        push_exp("wr_req_cycles", 32'd4); check(32'(n_req));
        push_exp("wr_eto", 32'd1);        check(32'(ifc.err_timeout));
        push_exp("wr_done_stall", 32'd0); check(32'(ifc.stall));
        push_exp("wr_done_req", 32'd0);   check(32'(ifc.mem_req));
        ifc.cw        = mk_cw(4'h3, 19'd0, 3'b000, 1'b0, 5'd4);
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = 8'h3C;
        tick();
        tick();
        ifc.mem_ack   = 1'b0;
        push_exp("wr_late_rdata", 32'h5A); check(32'(ifc.rdata));
        push_exp("wr_late_rv", 32'd0);     check(32'(n_rv));
        push_exp("wr_late_req", 32'd0);    check(32'(ifc.mem_req));

        // Illegal bus code.
        ifc.cw = mk_cw(4'h6, 19'd0, 3'b000, 1'b0, 5'd25);
        tick();
        push_exp("ill_src_oe", 32'd0);   check(32'(ifc.bus_oe));
        push_exp("ill_src_eill", 32'd1); check(32'(ifc.err_illegal));

        // Reset clears the sticky flags asynchronously.
        rst_n = 1'b0;
        #1;
        check_all_zero("rst2");
        tick();
        rst_n = 1'b1;

        // Illegal memory field 110 behaves as no access.
        ifc.cw = mk_cw(4'h9, 19'd0, 3'b110, 1'b0, 5'd2);
        #1;
        push_exp("ill_mem_stall", 32'd0); check(32'(ifc.stall));
        n_req = 0;
        tick();
        push_exp("ill_mem_eill", 32'd1); check(32'(ifc.err_illegal));
        push_exp("ill_mem_oe", 32'h4);   check(32'(ifc.bus_oe));
        tick();
        push_exp("ill_mem_req", 32'd0);  check(32'(n_req));

        // Reset in the middle of an access.
        ifc.cw = mk_cw(4'h8, 19'd0, 3'b010, 1'b0, 5'd1);
        tick();
        push_exp("mid_req_pre", 32'd1); check(32'(ifc.mem_req));
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("mid_req", 32'd0);   check(32'(ifc.mem_req));
        push_exp("mid_stall", 32'd0); check(32'(ifc.stall));
        tick();
        ifc.cw  = mk_cw(4'h0, 19'd0, 3'b000, 1'b0, 5'd0);
        rst_n   = 1'b1;
        n_rv    = 0;
        n_req   = 0;
        tick();
        tick();
        push_exp("mid_rv", 32'd0);    check(32'(n_rv));
        push_exp("mid_req2", 32'd0);  check(32'(n_req));
        push_exp("mid_rdata", 32'd0); check(32'(ifc.rdata));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
